memory_stage_mc: RTL and testbench

Parametrised, multi-cycle successor of the single-cycle memory pipeline stage. It sits between the EX/MEM and MEM/WB boundaries of the processor pipeline and owns a word-addressed data memory. Memory accesses take a configurable number of cycles, and the stage back-pressures the upstream pipeline through a stall output while an access is in flight. All results and control are delivered to writeback through a registered MEM/WB interface, with valid/bubble signalling, flush support and out-of-range address detection.

---
 rtl/mem_stage_pkg.sv | 22 ++
 rtl/data_memory_p.sv | 33 +++
 rtl/memory_stage_mc.sv | 163 ++++++++++++++++
 tb/tb_memory_stage_mc.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the multi-cycle memory stage.
//   state_e     : FSM state encoding (IDLE, BUSY)
//   DEF_*       : default parameter values
//   idx_width() : memory index width for a given depth
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int unsigned DEF_DATA_W      = 22;
  localparam int unsigned DEF_REG_ADDR_W  = 4;
  localparam int unsigned DEF_MEM_DEPTH   = 256;
  localparam int unsigned DEF_MEM_LATENCY = 1;

  // Number of address bits needed to index a memory of the given depth.
  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/data_memory_p.sv
// Word-addressed data memory: synchronous write with enable, combinational read.
// Contents are intentionally not reset.
//   clk   : write clock
//   we    : write enable
//   addr  : word index (shared by read and write)
//   wdata : write data
//   rdata : combinational read data at addr
module data_memory_p
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [idx_width(MEM_DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]               wdata,
  output logic [DATA_W-1:0]               rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read port
  assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage_mc.sv
// Multi-cycle MEM pipeline stage between EX/MEM and MEM/WB.
// Memory ops occupy the stage for MEM_LATENCY cycles and stall upstream
// meanwhile; non-memory ops pass in one cycle. Results are registered into
// the MEM/WB interface with valid/bubble signalling, flush and range check.
//   clk, rst                : clock, async active-high reset
//   flush_m                 : discard the op currently in the stage
//   valid_m, *_m            : op and control/data from EX/MEM
//   stall_m                 : combinational upstream hold
//   valid_w, *_w            : registered MEM/WB outputs
//   addr_err_w              : registered out-of-range flag for memory ops
module memory_stage_mc
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int unsigned MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_m,
  input  logic                  valid_m,
  input  logic                  pc_src_m,
  input  logic                  reg_write_m,
  input  logic                  mem_reg_m,
  input  logic                  mem_write_m,
  input  logic [DATA_W-1:0]     alu_result_m,
  input  logic [DATA_W-1:0]     write_data_m,
  input  logic [REG_ADDR_W-1:0] write_register_m,
  output logic                  stall_m,
  output logic                  valid_w,
  output logic                  pc_src_w,
  output logic                  reg_write_w,
  output logic                  mem_reg_w,
  output logic [DATA_W-1:0]     read_data_w,
  output logic [DATA_W-1:0]     alu_result_w,
  output logic [REG_ADDR_W-1:0] write_register_w,
  output logic                  addr_err_w
);

  localparam int unsigned AW    = idx_width(MEM_DEPTH);
  localparam int unsigned CNT_W = $clog2(MEM_LATENCY) + 1;

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic              mem_op_c;
  logic              oor_c;
  logic              complete_c;
  logic              stall_c;
  logic              mem_we_c;
  logic [AW-1:0]     idx_c;
  logic [DATA_W-1:0] mem_rdata_c;
  logic [DATA_W-1:0] rd_data_c;

  assign mem_op_c = valid_m & (mem_reg_m | mem_write_m);
  assign idx_c    = alu_result_m[AW-1:0];

  // Any address bit above the index range marks the access out of range.
  generate
    if (DATA_W > AW) begin : g_range
      assign oor_c = |alu_result_m[DATA_W-1:AW];
    end else begin : g_no_range
      assign oor_c = 1'b0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state, completion and stall; flush overrides everything.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    complete_c = 1'b0;
    stall_c    = 1'b0;
    if (flush_m) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_m) begin
            if (!mem_op_c || MEM_LATENCY == 1) begin
              complete_c = 1'b1;
            end else begin
              state_n = BUSY;
              cnt_n   = CNT_W'(MEM_LATENCY - 2);
              stall_c = 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            complete_c = 1'b1;
            state_n    = IDLE;
          end else begin
            cnt_n   = cnt - CNT_W'(1);
            stall_c = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign stall_m = stall_c;

  // Stores commit only on the completion edge and only when in range.
  assign mem_we_c  = complete_c & valid_m & mem_write_m & ~oor_c;
  assign rd_data_c = oor_c ? '0 : mem_rdata_c;

  data_memory_p #(
    .DATA_W   (DATA_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_data_memory (
    .clk  (clk),
    .we   (mem_we_c),
    .addr (idx_c),
    .wdata(write_data_m),
    .rdata(mem_rdata_c)
  );

  // MEM/WB registers: load on completion, otherwise bubble control and hold data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_w          <= 1'b0;
      pc_src_w         <= 1'b0;
      reg_write_w      <= 1'b0;
      mem_reg_w        <= 1'b0;
      read_data_w      <= '0;
      alu_result_w     <= '0;
      write_register_w <= '0;
      addr_err_w       <= 1'b0;
    end else if (complete_c) begin
      valid_w          <= 1'b1;
      pc_src_w         <= pc_src_m;
      reg_write_w      <= reg_write_m;
      mem_reg_w        <= mem_reg_m;
      read_data_w      <= rd_data_c;
      alu_result_w     <= alu_result_m;
      write_register_w <= write_register_m;
      addr_err_w       <= mem_op_c & oor_c;
    end else begin
      valid_w     <= 1'b0;
      pc_src_w    <= 1'b0;
      reg_write_w <= 1'b0;
      mem_reg_w   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_stage_mc.sv
// Self-checking bench for memory_stage_mc. Four instances with MEM_LATENCY
// 1..4 share the input buses; each has its own valid_m, so only the lane
// being exercised ever sees an op.
module tb_memory_stage_mc;

  localparam int NL = 4;

  logic        clk;
  logic        rst;
  logic        flush_m;
  logic        valid_m [NL];
  logic        pc_src_m, reg_write_m, mem_reg_m, mem_write_m;
  logic [21:0] alu_result_m, write_data_m;
  logic [3:0]  write_register_m;

  logic        stall_m [NL];
  logic        valid_w [NL];
  logic        pc_src_w [NL];
  logic        reg_write_w [NL];
  logic        mem_reg_w [NL];
  logic [21:0] read_data_w [NL];
  logic [21:0] alu_result_w [NL];
  logic [3:0]  write_register_w [NL];
  logic        addr_err_w [NL];

  for (genvar g = 0; g < NL; g++) begin : g_dut
    memory_stage_mc #(
      .DATA_W(22), .REG_ADDR_W(4), .MEM_DEPTH(256), .MEM_LATENCY(g + 1)
    ) u_dut (
      .clk(clk), .rst(rst), .flush_m(flush_m), .valid_m(valid_m[g]),
      .pc_src_m(pc_src_m), .reg_write_m(reg_write_m), .mem_reg_m(mem_reg_m),
      .mem_write_m(mem_write_m), .alu_result_m(alu_result_m),
      .write_data_m(write_data_m), .write_register_m(write_register_m),
      .stall_m(stall_m[g]), .valid_w(valid_w[g]), .pc_src_w(pc_src_w[g]),
      .reg_write_w(reg_write_w[g]), .mem_reg_w(mem_reg_w[g]),
      .read_data_w(read_data_w[g]), .alu_result_w(alu_result_w[g]),
      .write_register_w(write_register_w[g]), .addr_err_w(addr_err_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: memory image per lane and expected MEM/WB contents.
  logic [21:0] mem_model [NL][256];
  bit          known     [NL][256];
  bit          e_valid [NL], e_pc [NL], e_rw [NL], e_mr [NL], e_err [NL];
  logic [21:0] e_rd [NL], e_alu [NL];
  bit          e_rd_known [NL];
  logic [3:0]  e_wr [NL];
  bit          vq [$];

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      e_valid[l] = 0; e_pc[l] = 0; e_rw[l] = 0; e_mr[l] = 0; e_err[l] = 0;
      e_rd[l] = '0; e_alu[l] = '0; e_wr[l] = '0; e_rd_known[l] = 1;
    end
  endtask

  task automatic clear_inputs();
    flush_m = 0; pc_src_m = 0; reg_write_m = 0; mem_reg_m = 0; mem_write_m = 0;
    alu_result_m = '0; write_data_m = '0; write_register_m = '0;
    for (int l = 0; l < NL; l++) valid_m[l] = 0;
  endtask

  // Present one op to a lane and hold it until it completes or is flushed.
  // Called at posedge+1; returns at posedge+1 so ops can run back to back.
  task automatic run_op(input int lane, input bit ld, input bit st, input bit rw,
                        input bit pcs, input logic [21:0] a, input logic [21:0] wd,
                        input logic [3:0] rd, input int flush_cyc);
    bit mem, oor, done, exp_stall, fl;
    int lat, idx;
    mem = ld | st;
    lat = mem ? lane + 1 : 1;
    oor = (a[21:8] != 14'd0);
    idx = int'(a[7:0]);
    mem_reg_m = ld; mem_write_m = st; reg_write_m = rw; pc_src_m = pcs;
    alu_result_m = a; write_data_m = wd; write_register_m = rd;
    valid_m[lane] = 1;
    done = 0;
    for (int c = 0; c < lat && !done; c++) begin
      fl = (c == flush_cyc);
      flush_m = fl;
      #2;
      exp_stall = mem && (c < lat - 1) && !fl;
      checks++;
      if (stall_m[lane] !== exp_stall) begin
        failures++;
        $display("FAIL stall lane=%0d cyc=%0d got=%b exp=%b", lane, c, stall_m[lane], exp_stall);
      end
      @(posedge clk); #1;
      if (!fl && c == lat - 1) begin
        e_valid[lane] = 1; e_pc[lane] = pcs; e_rw[lane] = rw; e_mr[lane] = ld;
        e_alu[lane] = a; e_wr[lane] = rd; e_err[lane] = mem && oor;
        e_rd_known[lane] = oor || known[lane][idx];
        e_rd[lane] = oor ? 22'd0 : mem_model[lane][idx];
        if (st && !oor) begin
          mem_model[lane][idx] = wd;
          known[lane][idx] = 1;
        end
      end else begin
        e_valid[lane] = 0; e_pc[lane] = 0; e_rw[lane] = 0; e_mr[lane] = 0;
        if (fl) done = 1;
      end
      vq.push_back(valid_w[lane]);
      checks++;
      if (valid_w[lane] !== e_valid[lane] || pc_src_w[lane] !== e_pc[lane] ||
          reg_write_w[lane] !== e_rw[lane] || mem_reg_w[lane] !== e_mr[lane]) begin
        failures++;
        $display("FAIL ctrl lane=%0d cyc=%0d got v/pc/rw/mr=%b%b%b%b exp=%b%b%b%b", lane, c,
                 valid_w[lane], pc_src_w[lane], reg_write_w[lane], mem_reg_w[lane],
                 e_valid[lane], e_pc[lane], e_rw[lane], e_mr[lane]);
      end
      checks++;
      if (alu_result_w[lane] !== e_alu[lane] || write_register_w[lane] !== e_wr[lane] ||
          addr_err_w[lane] !== e_err[lane]) begin
        failures++;
        $display("FAIL data lane=%0d cyc=%0d got alu=%h wr=%h err=%b exp alu=%h wr=%h err=%b",
                 lane, c, alu_result_w[lane], write_register_w[lane], addr_err_w[lane],
                 e_alu[lane], e_wr[lane], e_err[lane]);
      end
      if (e_rd_known[lane]) begin
        checks++;
        if (read_data_w[lane] !== e_rd[lane]) begin
          failures++;
          $display("FAIL read_data lane=%0d cyc=%0d got=%h exp=%h", lane, c,
                   read_data_w[lane], e_rd[lane]);
        end
      end
    end
    valid_m[lane] = 0;
    flush_m = 0;
  endtask

  task automatic check_zero(input int lane, input string tag);
    checks++;
    if (stall_m[lane] !== 1'b0 || valid_w[lane] !== 1'b0 || pc_src_w[lane] !== 1'b0 ||
        reg_write_w[lane] !== 1'b0 || mem_reg_w[lane] !== 1'b0 || read_data_w[lane] !== 22'd0 ||
        alu_result_w[lane] !== 22'd0 || write_register_w[lane] !== 4'd0 ||
        addr_err_w[lane] !== 1'b0) begin
      failures++;
      $display("FAIL %s lane=%0d got st/v=%b%b rd=%h alu=%h wr=%h err=%b exp all zero", tag, lane,
               stall_m[lane], valid_w[lane], read_data_w[lane], alu_result_w[lane],
               write_register_w[lane], addr_err_w[lane]);
    end
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs(); model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int l = 0; l < NL; l++) check_zero(l, "reset");
    rst = 0;
  endtask

  task automatic test_alu_basic();
    run_op(0, 0, 0, 1, 0, 22'h00055, 22'h0, 4'h3, -1);
    checks++;
    if (valid_w[0] !== 1'b1 || alu_result_w[0] !== 22'h00055 || write_register_w[0] !== 4'h3) begin
      failures++;
      $display("FAIL alu_basic got v=%b alu=%h wr=%h exp v=1 alu=00055 wr=3",
               valid_w[0], alu_result_w[0], write_register_w[0]);
    end
  endtask

  task automatic test_store_load();
    run_op(2, 0, 1, 0, 0, 22'd7, 22'h12345, 4'h1, -1);
    run_op(2, 1, 0, 1, 0, 22'd7, 22'h0, 4'h2, -1);
    checks++;
    if (read_data_w[2] !== 22'h12345 || mem_reg_w[2] !== 1'b1) begin
      failures++;
      $display("FAIL store_load got rd=%h mr=%b exp rd=12345 mr=1", read_data_w[2], mem_reg_w[2]);
    end
  endtask

  task automatic test_out_of_range();
    run_op(0, 0, 1, 0, 0, 22'h00000, 22'h0abcd, 4'h0, -1);
    run_op(0, 0, 1, 0, 0, 22'h00100, 22'h3ffff, 4'h0, -1);
    checks++;
    if (addr_err_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL oor_store_err got=%b exp=1", addr_err_w[0]);
    end
    run_op(0, 1, 0, 1, 0, 22'h00100, 22'h0, 4'h5, -1);
    checks++;
    if (addr_err_w[0] !== 1'b1 || read_data_w[0] !== 22'd0) begin
      failures++;
      $display("FAIL oor_load got err=%b rd=%h exp err=1 rd=0", addr_err_w[0], read_data_w[0]);
    end
    run_op(0, 1, 0, 1, 0, 22'h00000, 22'h0, 4'h6, -1);
    checks++;
    if (addr_err_w[0] !== 1'b0 || read_data_w[0] !== 22'h0abcd) begin
      failures++;
      $display("FAIL inrange_after_oor got err=%b rd=%h exp err=0 rd=0abcd",
               addr_err_w[0], read_data_w[0]);
    end
  endtask

  task automatic test_flush();
    run_op(3, 0, 1, 0, 0, 22'd5, 22'h00777, 4'h0, -1);
    run_op(3, 0, 1, 0, 0, 22'd5, 22'h2aaaa, 4'h0, 1);
    checks++;
    if (valid_w[3] !== 1'b0) begin
      failures++;
      $display("FAIL flush_valid got=%b exp=0", valid_w[3]);
    end
    run_op(3, 1, 0, 1, 0, 22'd5, 22'h0, 4'h7, -1);
    checks++;
    if (read_data_w[3] !== 22'h00777) begin
      failures++;
      $display("FAIL flush_nostore got=%h exp=00777", read_data_w[3]);
    end
  endtask

  task automatic test_reset_mid_busy();
    run_op(2, 0, 1, 0, 0, 22'd9, 22'h01111, 4'h0, -1);
    mem_write_m = 1; mem_reg_m = 0; alu_result_m = 22'd9; write_data_m = 22'h02222;
    valid_m[2] = 1;
    @(posedge clk); #1;
    checks++;
    if (stall_m[2] !== 1'b1) begin
      failures++;
      $display("FAIL busy_stall got=%b exp=1", stall_m[2]);
    end
    rst = 1; valid_m[2] = 0;
    #1;
    check_zero(2, "reset_mid_busy");
    model_reset();
    @(posedge clk); #1;
    rst = 0; clear_inputs();
    run_op(2, 1, 0, 1, 0, 22'd9, 22'h0, 4'h4, -1);
    checks++;
    if (read_data_w[2] !== 22'h01111) begin
      failures++;
      $display("FAIL reset_abort_store got=%h exp=01111", read_data_w[2]);
    end
  endtask

  task automatic test_interleave();
    logic [3:0] pat;
    vq.delete();
    run_op(1, 0, 0, 1, 1, 22'h00011, 22'h0, 4'h1, -1);
    run_op(1, 1, 0, 1, 0, 22'd7, 22'h0, 4'h2, -1);
    run_op(1, 0, 0, 1, 0, 22'h00033, 22'h0, 4'h3, -1);
    pat = '0;
    for (int i = 0; i < vq.size() && i < 4; i++) pat[3 - i] = vq[i];
    checks++;
    if (vq.size() != 4 || pat !== 4'b1011) begin
      failures++;
      $display("FAIL interleave got n=%0d pattern=%b exp n=4 pattern=1011", vq.size(), pat);
    end
  endtask

  task automatic test_random();
    logic [21:0] a;
    int          kind, lat, fc;
    for (int l = 0; l < NL; l++) begin
      for (int n = 0; n < 40; n++) begin
        kind = $urandom_range(0, 2);
        if ($urandom_range(0, 4) == 0) a = 22'($urandom) | 22'h00100;
        else a = 22'($urandom_range(0, 15));
        lat = (kind == 0) ? 1 : l + 1;
        fc = ($urandom_range(0, 7) == 0) ? $urandom_range(0, lat - 1) : -1;
        run_op(l, kind == 1, kind == 2, 1'($urandom), 1'($urandom), a, 22'($urandom),
               4'($urandom), fc);
        if ($urandom_range(0, 5) == 0) begin
          @(posedge clk); #1;
          e_valid[l] = 0; e_pc[l] = 0; e_rw[l] = 0; e_mr[l] = 0;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu_basic();
    test_store_load();
    test_out_of_range();
    test_flush();
    test_reset_mid_busy();
    test_interleave();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
